// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite register bridge: response codes and
// the write/read channel state encodings.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_COLLECT = 2'd0,
        W_ISSUE   = 2'd1,
        W_RESP    = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_timeout_counter.sv
// Read-wait watchdog: down-counter loaded on start, flags expiry on the
// RD_TIMEOUT-th waiting cycle. Only used when AXI4_LITE_REG_BRIDGE_TIMEOUT_EN is defined.
module axi4_lite_timeout_counter #(
    parameter int RD_TIMEOUT = 255
) (
    input  logic S_AXI_ACLK,
    input  logic S_AXI_ARESET,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(RD_TIMEOUT - 1);

    logic [CNT_W-1:0] count;
    logic             running;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            count   <= LOAD;
            running <= 1'b1;
        end else if (clear) begin
            running <= 1'b0;
        end else if (running && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Count reaches zero on the last allowed waiting cycle.
    assign expired = running && (count == '0);

endmodule

// File: rtl/axi4_lite_reg_bridge.sv
// AXI4-Lite slave to local register-bus bridge with address range decode.
// Optional read timeout (SLVERR) enabled by defining AXI4_LITE_REG_BRIDGE_TIMEOUT_EN.
//
// state      | meaning
// W_COLLECT  | accepting AW and W independently, either order
// W_ISSUE    | both captured; local_wen pulses if address in range
// W_RESP     | BVALID held until BREADY
// R_IDLE     | ARREADY high, waiting for AR
// R_WAIT     | local_ren issued, waiting for local_rdatavalid (or timeout)
// R_RESP     | RVALID held until RREADY
module axi4_lite_reg_bridge
    import axi4_lite_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int REG_ADDR_BIT       = 8,
    parameter int C_S_AXI_ADDR_WIDTH = REG_ADDR_BIT + $clog2(C_S_AXI_DATA_WIDTH/8),
    parameter int REG_NUM            = 2**REG_ADDR_BIT,
    parameter int RD_TIMEOUT         = 255
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [REG_ADDR_BIT-1:0]           local_waddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     local_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   local_wstrb,
    output logic                              local_wen,
    output logic [REG_ADDR_BIT-1:0]           local_raddr,
    output logic                              local_ren,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     local_rdata,
    input  logic                              local_rdatavalid
);

    localparam int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH/8);
    localparam int STRB_W   = C_S_AXI_DATA_WIDTH/8;
    // One extra bit so REG_NUM == 2**REG_ADDR_BIT is representable.
    localparam logic [REG_ADDR_BIT:0] REG_LIMIT = (REG_ADDR_BIT+1)'(REG_NUM);

    function automatic logic in_range(input logic [REG_ADDR_BIT-1:0] word);
        return {1'b0, word} < REG_LIMIT;
    endfunction

    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // ---------------- write channel ----------------
    wr_state_t                 wr_state, wr_next;
    logic                      aw_full, w_full, aw_full_d, w_full_d;
    logic                      awready_q, wready_q;
    logic                      aw_hs, w_hs;
    logic [REG_ADDR_BIT-1:0]   waddr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]         wstrb_q;
    logic [1:0]                bresp_q;

    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID  && wready_q;

    always_comb begin
        wr_next   = wr_state;
        aw_full_d = aw_full || aw_hs;
        w_full_d  = w_full  || w_hs;
        case (wr_state)
            W_COLLECT: if (aw_full_d && w_full_d) wr_next = W_ISSUE;
            W_ISSUE:   wr_next = W_RESP;
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wr_next   = W_COLLECT;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                end
            end
            default:   wr_next = W_COLLECT;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state  <= W_COLLECT;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wr_state  <= wr_next;
            aw_full   <= aw_full_d;
            w_full    <= w_full_d;
            awready_q <= ~aw_full_d;
            wready_q  <= ~w_full_d;
            if (aw_hs) waddr_q <= REG_ADDR_BIT'(S_AXI_AWADDR >> ADDR_LSB);
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (wr_state == W_ISSUE)
                bresp_q <= in_range(waddr_q) ? RESP_OKAY : RESP_DECERR;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = (wr_state == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign local_waddr   = waddr_q;
    assign local_wdata   = wdata_q;
    assign local_wstrb   = wstrb_q;
    assign local_wen     = (wr_state == W_ISSUE) && in_range(waddr_q);

    // ---------------- read channel ----------------
    rd_state_t                 rd_state, rd_next;
    logic                      arready_q, ar_hs, ren_q, rd_expired;
    logic [REG_ADDR_BIT-1:0]   ar_word, raddr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;

    assign ar_hs   = S_AXI_ARVALID && arready_q;
    assign ar_word = REG_ADDR_BIT'(S_AXI_ARADDR >> ADDR_LSB);

`ifdef AXI4_LITE_REG_BRIDGE_TIMEOUT_EN
    logic rd_start, rd_clear;
    assign rd_start = (rd_state == R_IDLE) && ar_hs && in_range(ar_word);
    assign rd_clear = (rd_state == R_WAIT) && (local_rdatavalid || rd_expired);

    axi4_lite_timeout_counter #(
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_rd_timeout (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESET (S_AXI_ARESET),
        .start        (rd_start),
        .clear        (rd_clear),
        .expired      (rd_expired)
    );
`else
    assign rd_expired = 1'b0;
`endif

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE: if (ar_hs) rd_next = in_range(ar_word) ? R_WAIT : R_RESP;
            R_WAIT: if (local_rdatavalid || rd_expired) rd_next = R_RESP;
            R_RESP: if (S_AXI_RREADY) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b0;
            ren_q     <= 1'b0;
            raddr_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rd_state  <= rd_next;
            arready_q <= (rd_next == R_IDLE);
            ren_q     <= 1'b0;
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        raddr_q <= ar_word;
                        if (in_range(ar_word)) begin
                            ren_q <= 1'b1;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_DECERR;
                        end
                    end
                end
                R_WAIT: begin
                    // Data arriving in the expiry cycle takes priority over the timeout.
                    if (local_rdatavalid) begin
                        rdata_q <= local_rdata;
                        rresp_q <= RESP_OKAY;
                    end else if (rd_expired) begin
                        rdata_q <= '0;
                        rresp_q <= RESP_SLVERR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = (rd_state == R_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign local_raddr   = raddr_q;
    assign local_ren     = ren_q;

endmodule

// File: tb/tb_axi4_lite_reg_bridge.sv
// Self-checking bench for axi4_lite_reg_bridge; expected responses are queued
// at stimulus time and popped when the DUT responds.
module tb_axi4_lite_reg_bridge;
    import axi4_lite_pkg::*;

    localparam int DW   = 32;
    localparam int RAB  = 8;
    localparam int AW   = 10;
    localparam int NREG = 16;
    localparam int TMO  = 4;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [AW-1:0]   awaddr = '0, araddr = '0;
    logic [2:0]      awprot = '0, arprot = '0;
    logic            awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [DW-1:0]   wdata = '0, rdata;
    logic [DW/8-1:0] wstrb = '0;
    logic [1:0]      bresp, rresp;
    logic [RAB-1:0]  local_waddr, local_raddr;
    logic [DW-1:0]   local_wdata;
    logic [DW/8-1:0] local_wstrb;
    logic            local_wen, local_ren;
    logic [DW-1:0]   local_rdata = '0;
    logic            local_rdatavalid = 0;

    always #5 aclk = ~aclk;

    axi4_lite_reg_bridge #(
        .C_S_AXI_DATA_WIDTH (DW),
        .REG_ADDR_BIT       (RAB),
        .C_S_AXI_ADDR_WIDTH (AW),
        .REG_NUM            (NREG),
        .RD_TIMEOUT         (TMO)
    ) dut (
        .S_AXI_ACLK       (aclk),
        .S_AXI_ARESET     (areset),
        .S_AXI_AWADDR     (awaddr),
        .S_AXI_AWPROT     (awprot),
        .S_AXI_AWVALID    (awvalid),
        .S_AXI_AWREADY    (awready),
        .S_AXI_WDATA      (wdata),
        .S_AXI_WSTRB      (wstrb),
        .S_AXI_WVALID     (wvalid),
        .S_AXI_WREADY     (wready),
        .S_AXI_BRESP      (bresp),
        .S_AXI_BVALID     (bvalid),
        .S_AXI_BREADY     (bready),
        .S_AXI_ARADDR     (araddr),
        .S_AXI_ARPROT     (arprot),
        .S_AXI_ARVALID    (arvalid),
        .S_AXI_ARREADY    (arready),
        .S_AXI_RDATA      (rdata),
        .S_AXI_RRESP      (rresp),
        .S_AXI_RVALID     (rvalid),
        .S_AXI_RREADY     (rready),
        .local_waddr      (local_waddr),
        .local_wdata      (local_wdata),
        .local_wstrb      (local_wstrb),
        .local_wen        (local_wen),
        .local_raddr      (local_raddr),
        .local_ren        (local_ren),
        .local_rdata      (local_rdata),
        .local_rdatavalid (local_rdatavalid)
    );

    typedef struct {
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } rexp_t;

    typedef struct {
        logic [RAB-1:0]  addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
    } wr_t;

    logic [1:0]     exp_b[$];
    rexp_t          exp_r[$];
    wr_t            obs_wr[$];
    logic [RAB-1:0] ren_addr[$];
    int n_pass  = 0;
    int n_total = 0;

    // Record every local strobe for later comparison.
    always @(negedge aclk) begin : monitor
        wr_t t;
        if (local_wen) begin
            t.addr = local_waddr;
            t.data = local_wdata;
            t.strb = local_wstrb;
            obs_wr.push_back(t);
        end
        if (local_ren) ren_addr.push_back(local_raddr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_r(input logic [1:0] resp, input logic [DW-1:0] data);
        rexp_t e;
        e.resp = resp;
        e.data = data;
        exp_r.push_back(e);
    endtask

    task automatic collect_b(input string name);
        int n;
        logic [1:0] e;
        n = 0;
        while (!bvalid && n < 20) begin step(); n++; end
        n_total++;
        if (!bvalid)
            $display("FAIL %s: bvalid never asserted", name);
        else if (exp_b.size() == 0)
            $display("FAIL %s: unexpected B response bresp=%b", name, bresp);
        else begin
            e = exp_b.pop_front();
            if (bresp !== e) $display("FAIL %s: bresp=%b expected %b", name, bresp, e);
            else n_pass++;
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic collect_r(input string name);
        int n;
        rexp_t e;
        n = 0;
        while (!rvalid && n < 20) begin step(); n++; end
        n_total++;
        if (!rvalid)
            $display("FAIL %s: rvalid never asserted", name);
        else if (exp_r.size() == 0)
            $display("FAIL %s: unexpected R response rresp=%b", name, rresp);
        else begin
            e = exp_r.pop_front();
            if ({rresp, rdata} !== {e.resp, e.data})
                $display("FAIL %s: rresp/rdata=%b/%h expected %b/%h", name, rresp, rdata, e.resp, e.data);
            else n_pass++;
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        n_total++;
        if ({rvalid, arready} !== 2'b01)
            $display("FAIL %s after handshake: rvalid/arready=%b expected 01", name, {rvalid, arready});
        else n_pass++;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW/8-1:0] s, input logic [1:0] resp);
        int  n;
        bit  aw_go, w_go;
        exp_b.push_back(resp);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_go = awready;
            w_go  = wready;
            step();
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
            n++;
        end
        if (awvalid || wvalid) begin
            n_total++;
            $display("FAIL write handshake: awvalid/wvalid still pending=%b expected 00", {awvalid, wvalid});
            awvalid = 1'b0; wvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_total++;
        if ({awready, wready, arready, bvalid, rvalid, local_wen, local_ren} !== 7'b0)
            $display("FAIL reset handshake outputs: got %b expected 0",
                     {awready, wready, arready, bvalid, rvalid, local_wen, local_ren});
        else n_pass++;
        n_total++;
        if ({bresp, rresp, rdata, local_waddr, local_wdata, local_wstrb, local_raddr} !== '0)
            $display("FAIL reset buses: got nonzero value %h",
                     {bresp, rresp, rdata, local_waddr, local_wdata, local_wstrb, local_raddr});
        else n_pass++;
        areset = 1'b0;
        step();
        n_total++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100)
            $display("FAIL ready after reset: got %b expected 11100", {awready, wready, arready, bvalid, rvalid});
        else n_pass++;
    endtask

    task automatic test_w_before_aw();
        obs_wr.delete();
        exp_b.push_back(RESP_OKAY);
        wdata = 32'hA5A5_0001; wstrb = 4'h3; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        n_total++;
        if ({wready, awready} !== 2'b01)
            $display("FAIL w_first readies: wready/awready=%b expected 01", {wready, awready});
        else n_pass++;
        step();
        step();
        awaddr = 10'h010; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        n_total++;
        if ({local_wen, local_waddr, local_wstrb, local_wdata} !== {1'b1, 8'h04, 4'h3, 32'hA5A5_0001})
            $display("FAIL w_first local write: wen/addr/strb/data=%b/%h/%h/%h expected 1/04/3/a5a50001",
                     local_wen, local_waddr, local_wstrb, local_wdata);
        else n_pass++;
        n_total++;
        if (bvalid !== 1'b0) $display("FAIL w_first bvalid early: got %b expected 0", bvalid);
        else n_pass++;
        step();
        n_total++;
        if ({bvalid, local_wen} !== 2'b10)
            $display("FAIL w_first bvalid timing: bvalid/wen=%b expected 10", {bvalid, local_wen});
        else n_pass++;
        collect_b("w_first bresp");
        n_total++;
        if (obs_wr.size() != 1) $display("FAIL w_first wen count: got %0d expected 1", obs_wr.size());
        else n_pass++;
        n_total++;
        if ({awready, wready} !== 2'b11)
            $display("FAIL w_first ready after B: got %b expected 11", {awready, wready});
        else n_pass++;
    endtask

    task automatic test_slow_read();
        bit ok;
        ren_addr.delete();
        push_r(RESP_OKAY, 32'h1234_5678);
        araddr = 10'h008; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        n_total++;
        if ({local_ren, local_raddr, arready} !== {1'b1, 8'h02, 1'b0})
            $display("FAIL slow_read ren: ren/raddr/arready=%b/%h/%b expected 1/02/0", local_ren, local_raddr, arready);
        else n_pass++;
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rvalid || arready || local_ren) ok = 0;
        end
        n_total++;
        if (!ok) $display("FAIL slow_read wait: rvalid/arready/ren=%b expected 000", {rvalid, arready, local_ren});
        else n_pass++;
        local_rdata = 32'h1234_5678; local_rdatavalid = 1'b1;
        step();
        local_rdatavalid = 1'b0; local_rdata = 32'hDEAD_BEEF;
        n_total++;
        if (rvalid !== 1'b1) $display("FAIL slow_read rvalid timing: got %b expected 1", rvalid);
        else n_pass++;
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || rresp !== RESP_OKAY || arready !== 1'b0) ok = 0;
        end
        n_total++;
        if (!ok) $display("FAIL slow_read hold: rvalid/rdata/arready=%b/%h/%b expected 1/12345678/0", rvalid, rdata, arready);
        else n_pass++;
        collect_r("slow_read rdata");
        n_total++;
        if (ren_addr.size() != 1) $display("FAIL slow_read ren count: got %0d expected 1", ren_addr.size());
        else n_pass++;
    endtask

    task automatic test_decode_error();
        obs_wr.delete();
        ren_addr.delete();
        axi_write(10'h040, 32'hFFFF_FFFF, 4'hF, RESP_DECERR);
        collect_b("decerr bresp");
        n_total++;
        if (obs_wr.size() != 0) $display("FAIL decerr wen count: got %0d expected 0", obs_wr.size());
        else n_pass++;
        push_r(RESP_DECERR, '0);
        araddr = 10'h040; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        n_total++;
        if ({rvalid, local_ren} !== 2'b10)
            $display("FAIL decerr read timing: rvalid/ren=%b expected 10", {rvalid, local_ren});
        else n_pass++;
        collect_r("decerr read");
        n_total++;
        if (ren_addr.size() != 0) $display("FAIL decerr ren count: got %0d expected 0", ren_addr.size());
        else n_pass++;
    endtask

    task automatic test_read_wait();
        bit ok;
        araddr = 10'h00C; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
`ifdef AXI4_LITE_REG_BRIDGE_TIMEOUT_EN
        push_r(RESP_SLVERR, '0);
        ok = 1;
        for (int i = 0; i < TMO - 1; i++) begin
            step();
            if (rvalid) ok = 0;
        end
        n_total++;
        if (!ok) $display("FAIL timeout early: rvalid=%b expected 0", rvalid);
        else n_pass++;
        step();
        local_rdata = 32'h5555_0000; local_rdatavalid = 1'b1;
        step();
        local_rdatavalid = 1'b0;
        n_total++;
        if ({rvalid, rdata} !== {1'b1, 32'h0}) $display("FAIL late rdatavalid: rvalid/rdata=%b/%h expected 1/0", rvalid, rdata);
        else n_pass++;
        collect_r("timeout slverr");
        push_r(RESP_OKAY, 32'hCAFE_F00D);
        araddr = 10'h010; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        for (int i = 0; i < TMO - 1; i++) step();
        local_rdata = 32'hCAFE_F00D; local_rdatavalid = 1'b1;
        step();
        local_rdatavalid = 1'b0;
        collect_r("expiry race");
`else
        push_r(RESP_OKAY, 32'h0BAD_CAFE);
        ok = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rvalid) ok = 0;
        end
        n_total++;
        if (!ok) $display("FAIL no-timeout wait: rvalid=%b expected 0", rvalid);
        else n_pass++;
        local_rdata = 32'h0BAD_CAFE; local_rdatavalid = 1'b1;
        step();
        local_rdatavalid = 1'b0;
        collect_r("long wait read");
`endif
        local_rdata = 32'hFFFF_0000; local_rdatavalid = 1'b1;
        step();
        step();
        local_rdatavalid = 1'b0;
        n_total++;
        if ({rvalid, arready} !== 2'b01) $display("FAIL idle rdatavalid: rvalid/arready=%b expected 01", {rvalid, arready});
        else n_pass++;
    endtask

    task automatic test_concurrent();
        wr_t w;
        obs_wr.delete();
        ren_addr.delete();
        exp_b.push_back(RESP_OKAY);
        push_r(RESP_OKAY, 32'h0000_600D);
        awaddr = 10'h014; wdata = 32'h5555_AAAA; wstrb = 4'hF;
        araddr = 10'h018;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        n_total++;
        if ({local_wen, local_ren, local_waddr, local_raddr} !== {1'b1, 1'b1, 8'h05, 8'h06})
            $display("FAIL concurrent strobes: wen/ren/waddr/raddr=%b/%b/%h/%h expected 1/1/05/06",
                     local_wen, local_ren, local_waddr, local_raddr);
        else n_pass++;
        local_rdata = 32'h0000_600D; local_rdatavalid = 1'b1;
        step();
        local_rdatavalid = 1'b0;
        n_total++;
        if ({bvalid, rvalid} !== 2'b11) $display("FAIL concurrent valids: bvalid/rvalid=%b expected 11", {bvalid, rvalid});
        else n_pass++;
        collect_b("concurrent bresp");
        collect_r("concurrent read");
        n_total++;
        if (obs_wr.size() != 1) $display("FAIL concurrent wen count: got %0d expected 1", obs_wr.size());
        else begin
            w = obs_wr.pop_front();
            if ({w.addr, w.data, w.strb} !== {8'h05, 32'h5555_AAAA, 4'hF})
                $display("FAIL concurrent wdata: addr/data/strb=%h/%h/%h expected 05/5555aaaa/f", w.addr, w.data, w.strb);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        araddr = 10'h008; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        awaddr = 10'h000; wdata = 32'h77; wstrb = 4'h1;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        n_total++;
        if ({bvalid, rvalid} !== 2'b10) $display("FAIL midflight setup: bvalid/rvalid=%b expected 10", {bvalid, rvalid});
        else n_pass++;
        areset = 1'b1;
        step();
        n_total++;
        if ({awready, wready, arready, bvalid, rvalid, local_wen, local_ren, bresp, rresp, rdata,
             local_waddr, local_wdata, local_wstrb, local_raddr} !== '0)
            $display("FAIL midflight reset: outputs bvalid/rvalid/waddr/wdata/raddr=%b/%b/%h/%h/%h expected all 0",
                     bvalid, rvalid, local_waddr, local_wdata, local_raddr);
        else n_pass++;
        areset = 1'b0;
        step();
        local_rdata = 32'hBADB_AD00; local_rdatavalid = 1'b1;
        step();
        local_rdatavalid = 1'b0;
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bvalid || rvalid || !arready) ok = 0;
        end
        n_total++;
        if (!ok) $display("FAIL midflight no response: bvalid/rvalid/arready=%b expected 001", {bvalid, rvalid, arready});
        else n_pass++;
        push_r(RESP_OKAY, 32'h1111_2222);
        araddr = 10'h004; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        local_rdata = 32'h1111_2222; local_rdatavalid = 1'b1;
        step();
        local_rdatavalid = 1'b0;
        collect_r("fresh read after reset");
    endtask

    initial begin
        repeat (3) step();
        test_reset();
        test_w_before_aw();
        test_slow_read();
        test_decode_error();
        test_read_wait();
        test_concurrent();
        test_reset_midflight();
        n_total++;
        if (exp_b.size() + exp_r.size() != 0)
            $display("FAIL scoreboard drain: %0d B and %0d R still pending, expected 0", exp_b.size(), exp_r.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
